// File: rtl/pgm_sched_pkg.sv
// Shared constants for the packet-generator replay scheduler.
// Holds state encoding, word tags, RAM geometry and small helpers.
package pgm_sched_pkg;

  localparam int RAM_DEPTH = 128;
  localparam int RAM_W     = 144;
  localparam int ADDR_W    = 7;
  localparam int OUT_W     = 134;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  // The tail tag wins so a single-word packet still closes.
  function automatic logic [1:0] word_tag(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] last
  );
    logic [1:0] t;
    if (addr == last)
      t = TAG_TAIL;
    else if (addr == '0)
      t = TAG_HEAD;
    else
      t = TAG_BODY;
    return t;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pgm_sched_gap_cnt.sv
// Inter-packet gap counter: load, decrement to zero, zero flag.
// Stops at zero so a held gap never underflows.
module pgm_gap_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pgm_sched.sv
// Replays a stored packet from RAM, with programmable gap, count,
// stop and downstream back-pressure sampled between packets.
module pgm_sched
  import pgm_sched_pkg::*;
#(
  parameter logic [7:0] LMID  = 8'd62,
  parameter int         GAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] cfg_last_addr,
  input  logic [31:0]       cfg_pkt_cnt,
  input  logic [GAP_W-1:0]  cfg_gap,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [RAM_W-1:0]  ram_rd_data,
  input  logic              in_alf,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_data_wr,
  output logic              out_valid,
  output logic              out_valid_wr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       sent_cnt
);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nx;
  logic [ADDR_W-1:0] last_q;
  logic [31:0]       cnt_q;
  logic [31:0]       issued;
  logic [31:0]       issued_nx;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_val;
  logic              gap_load;
  logic              gap_dec;
  logic              gap_zero;
  logic              v1;
  logic [1:0]        tag1;
  logic              launch;
  logic              reached_end;
  logic              reached_gap;
  logic              empty;
  logic              unused;

  assign unused = ^{LMID, ram_rd_data[RAM_W-1:OUT_W]};

  assign launch = (state == S_IDLE) && start;

  // Count is tracked on issued packets so the decision is ready
  // before the tail word has left the output register.
  assign reached_end = (cnt_q != '0) && (issued + 32'd1 == cnt_q);
  assign reached_gap = (cnt_q != '0) && (issued == cnt_q);
  assign empty       = !v1 && !out_data_wr;

  always_comb begin
    state_nx  = state;
    addr_nx   = addr;
    issued_nx = issued;
    gap_load  = 1'b0;
    gap_val   = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          addr_nx   = '0;
          issued_nx = '0;
          if (in_alf) begin
            state_nx = S_GAP;
            gap_load = 1'b1;
          end else begin
            state_nx = S_READ;
          end
        end
      end
      S_READ: begin
        if (addr == last_q) begin
          addr_nx   = '0;
          issued_nx = issued + 32'd1;
          if (stop) begin
            state_nx = S_DRAIN;
          end else if (gap_q == '0 && !in_alf) begin
            state_nx = reached_end ? S_DRAIN : S_READ;
          end else begin
            state_nx = S_GAP;
            gap_load = 1'b1;
            if (gap_q != '0)
              gap_val = gap_q - GAP_W'(1);
          end
        end else begin
          addr_nx = addr + ADDR_W'(1);
        end
      end
      S_GAP: begin
        if (stop)
          state_nx = S_DRAIN;
        else if (gap_zero && reached_gap)
          state_nx = S_DRAIN;
        else if (gap_zero && !in_alf)
          state_nx = S_READ;
      end
      S_DRAIN: begin
        if (empty)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign gap_dec = (state == S_GAP) && !gap_zero;

  pgm_gap_cnt #(
    .W(GAP_W)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_val),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      addr   <= '0;
      issued <= '0;
    end else begin
      state  <= state_nx;
      addr   <= addr_nx;
      issued <= issued_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
    end else if (launch) begin
      last_q <= cfg_last_addr;
      cnt_q  <= cfg_pkt_cnt;
      gap_q  <= cfg_gap;
    end
  end

  assign ram_rd_en   = (state == S_READ);
  assign ram_rd_addr = addr;

  // Stage 1 tracks the word inside the RAM; stage 2 is the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      tag1 <= TAG_BODY;
    end else begin
      v1   <= ram_rd_en;
      tag1 <= word_tag(addr, last_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data     <= '0;
      out_data_wr  <= 1'b0;
      out_valid    <= 1'b0;
      out_valid_wr <= 1'b0;
    end else begin
      out_data_wr  <= v1;
      out_valid    <= v1 && (tag1 == TAG_TAIL);
      out_valid_wr <= v1 && (tag1 == TAG_TAIL);
      if (v1)
        out_data <= ram_rd_data[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sent_cnt <= '0;
    else if (launch)
      sent_cnt <= '0;
    else if (out_valid_wr)
      sent_cnt <= sat_inc(sent_cnt);
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DRAIN) && empty;

endmodule

// File: tb/tb_pgm_sched.sv
// Self-checking bench for pgm_sched: directed table, random
// configurations against a timing-formula model, corner sequences.
module tb_pgm_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [6:0]   cfg_last_addr = '0;
  logic [31:0]  cfg_pkt_cnt = '0;
  logic [15:0]  cfg_gap = '0;
  logic         ram_rd_en;
  logic [6:0]   ram_rd_addr;
  logic [143:0] ram_rd_data = '0;
  logic         in_alf = 1'b0;
  logic [133:0] out_data;
  logic         out_data_wr;
  logic         out_valid;
  logic         out_valid_wr;
  logic         busy;
  logic         done;
  logic [31:0]  sent_cnt;

  logic [143:0] mem [128];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];

  pgm_sched #(
    .LMID (8'd62),
    .GAP_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .cfg_last_addr(cfg_last_addr),
    .cfg_pkt_cnt  (cfg_pkt_cnt),
    .cfg_gap      (cfg_gap),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .in_alf       (in_alf),
    .out_data     (out_data),
    .out_data_wr  (out_data_wr),
    .out_valid    (out_valid),
    .out_valid_wr (out_valid_wr),
    .busy         (busy),
    .done         (done),
    .sent_cnt     (sent_cnt)
  );

  typedef struct {
    int l;
    int n;
    int g;
    int done_cyc;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fill_mem();
    logic [159:0] t;
    for (int i = 0; i < 128; i++) begin
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      mem[i] = t[143:0];
    end
  endtask

  // Packet k word w leaves at cycle 3 + k*(l+1+g) + w.
  function automatic void model(input int l, input int n, input int g,
                                input int c, output logic wr,
                                output logic vld, output int w);
    int p;
    int off;
    p = l + 1 + g;
    off = c - 3;
    wr = 1'b0;
    vld = 1'b0;
    w = 0;
    if (off >= 0 && off <= (n - 1) * p + l) begin
      w = off % p;
      if (w <= l) begin
        wr = 1'b1;
        vld = (w == l);
      end
    end
  endfunction

  // Last read cycle, then the final gap or the 2-deep pipe, whichever is longer.
  function automatic int model_done(input int l, input int n, input int g);
    int r;
    r = n * (l + 1) + (n - 1) * g;
    return r + ((g + 1 > 3) ? g + 1 : 3);
  endfunction

  task automatic kick(input int l, input int n, input int g);
    @(negedge clk);
    cfg_last_addr = 7'(l);
    cfg_pkt_cnt = 32'(n);
    cfg_gap = 16'(g);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_cfg(input int l, input int n, input int g,
                         input int exp_done);
    logic wr;
    logic vld;
    int w;
    int dcyc;
    int dnum;
    int limit;
    fill_mem();
    limit = exp_done + 6;
    dcyc = -1;
    dnum = 0;
    kick(l, n, g);
    for (int c = 1; c <= limit; c++) begin
      if (c > 1) @(negedge clk);
      model(l, n, g, c, wr, vld, w);
      if ({out_data_wr, out_valid_wr, out_valid} !== {wr, vld, vld})
        chk($sformatf("strobe l%0d n%0d g%0d c%0d", l, n, g, c),
            {out_data_wr, out_valid_wr, out_valid}, {wr, vld, vld});
      if (wr && out_data_wr && out_data !== mem[w][133:0])
        chk($sformatf("data l%0d c%0d", l, c), out_data, mem[w][133:0]);
      if (done) begin
        dnum++;
        if (dcyc < 0) dcyc = c;
      end
    end
    chk($sformatf("done_cycle l%0d n%0d g%0d", l, n, g), dcyc, exp_done);
    chk("done_pulses", dnum, 1);
    chk("sent_cnt_end", sent_cnt, n);
    chk("idle_after", {busy, ram_rd_en}, 2'b00);
  endtask

  initial begin
    tbl[0] = '{l: 3,   n: 2, g: 4, done_cyc: 17};
    tbl[1] = '{l: 1,   n: 3, g: 0, done_cyc: 9};
    tbl[2] = '{l: 0,   n: 3, g: 1, done_cyc: 8};
    tbl[3] = '{l: 127, n: 1, g: 0, done_cyc: 131};
    tbl[4] = '{l: 2,   n: 1, g: 7, done_cyc: 11};

    #1;
    chk("reset_ctl",
        {ram_rd_en, ram_rd_addr, out_data_wr, out_valid, out_valid_wr,
         busy, done}, '0);
    chk("reset_data", out_data, '0);
    chk("reset_sent", sent_cnt, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_cfg(tbl[i].l, tbl[i].n, tbl[i].g, tbl[i].done_cyc);

    for (int i = 0; i < 8; i++) begin
      int l;
      int n;
      int g;
      l = $urandom_range(0, 9);
      n = $urandom_range(1, 4);
      g = $urandom_range(0, 5);
      run_cfg(l, n, g, model_done(l, n, g));
    end

    // Continuous run, stop raised in the middle of the 5th packet.
    begin
      int tails;
      int words;
      int dcyc;
      int dnum;
      fill_mem();
      tails = 0;
      words = 0;
      dcyc = -1;
      dnum = 0;
      kick(2, 0, 1);
      for (int c = 1; c <= 40; c++) begin
        if (c > 1) @(negedge clk);
        if (out_valid_wr) tails++;
        if (out_data_wr) words++;
        if (done) begin
          dnum++;
          if (dcyc < 0) dcyc = c;
        end
        if (c == 17) stop = 1'b1;
      end
      stop = 1'b0;
      chk("stop_tails", tails, 5);
      chk("stop_words", words, 15);
      chk("stop_done_cycle", dcyc, 22);
      chk("stop_done_pulses", dnum, 1);
      chk("stop_sent", sent_cnt, 5);
    end

    // Back-pressure held across the gap; first packet must not stall.
    begin
      logic [255:0] seen;
      logic [255:0] want;
      int dcyc;
      fill_mem();
      seen = '0;
      want = '0;
      want[3] = 1'b1;
      want[4] = 1'b1;
      want[14] = 1'b1;
      want[15] = 1'b1;
      dcyc = -1;
      kick(1, 2, 2);
      for (int c = 1; c <= 24; c++) begin
        if (c > 1) @(negedge clk);
        if (out_data_wr) seen[c] = 1'b1;
        if (done && dcyc < 0) dcyc = c;
        if (c == 1) in_alf = 1'b1;
        if (c == 11) in_alf = 1'b0;
      end
      chk("alf_wr_pattern", seen, want);
      chk("alf_done_cycle", dcyc, 16);
      chk("alf_sent", sent_cnt, 2);
    end

    // Reset mid-packet; a second start while busy is ignored.
    begin
      int leaks;
      fill_mem();
      kick(3, 1, 0);
      for (int c = 1; c <= 4; c++) begin
        if (c > 1) @(negedge clk);
        if (c == 2) begin
          cfg_last_addr = 7'd0;
          start = 1'b1;
        end
        if (c == 3) begin
          start = 1'b0;
          cfg_last_addr = 7'd3;
          chk("ign_start_addr", ram_rd_addr, 7'd2);
        end
        if (c == 4) begin
          chk("ign_start_data", {out_data_wr, out_valid_wr, out_data},
              {2'b10, mem[1][133:0]});
          rst = 1'b1;
          #1;
          chk("rst_mid_ctl",
              {ram_rd_en, ram_rd_addr, out_data_wr, out_valid,
               out_valid_wr, busy, done}, '0);
          chk("rst_mid_data", {out_data, sent_cnt}, '0);
        end
      end
      @(negedge clk);
      rst = 1'b0;
      leaks = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (out_data_wr || busy || ram_rd_en) leaks++;
      end
      chk("rst_no_leak", leaks, 0);
      run_cfg(3, 1, 0, model_done(3, 1, 0));
    end

    // Counter saturation with a continuous single-word stream.
    begin
      int dcyc;
      fill_mem();
      dcyc = -1;
      kick(0, 0, 0);
      for (int c = 1; c <= 30; c++) begin
        if (c > 1) @(negedge clk);
        if (c == 2) force dut.sent_cnt = 32'hFFFF_FFFE;
        if (c == 3) release dut.sent_cnt;
        if (c == 5) chk("sat_first", sent_cnt, 32'hFFFF_FFFF);
        if (c == 9) chk("sat_hold", sent_cnt, 32'hFFFF_FFFF);
        if (c == 9) stop = 1'b1;
        if (done && dcyc < 0) dcyc = c;
      end
      stop = 1'b0;
      chk("sat_done_seen", dcyc > 0, 1'b1);
      chk("sat_final", sent_cnt, 32'hFFFF_FFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pgm_sched.md
PGM_SCHED -- requirements
Module: pgm_sched

Interface
REQ-001 Parameter LMID, default 8'd62; MID of the packet-generator group. Informational only; it changes no logic.
REQ-002 Parameter GAP_W, default 16; width of cfg_gap.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle pulse; begins a replay run.
REQ-006 Port stop  input  1  level; abort request, honoured at a packet boundary.
REQ-007 Port cfg_last_addr  input  7  RAM address of the final stored word.
REQ-008 Port cfg_pkt_cnt  input  32  packets to send; 0 means continuous until stop.
REQ-009 Port cfg_gap  input  GAP_W  idle output cycles between packets.
REQ-010 Port ram_rd_en  output  1  RAM read strobe.
REQ-011 Port ram_rd_addr  output  7  RAM read address.
REQ-012 Port ram_rd_data  input  144  RAM data; valid 1 cycle after ram_rd_en.
REQ-013 Port in_alf  input  1  downstream almost-full.
REQ-014 Port out_data  output  134  packet word: ram_rd_data[133:0].
REQ-015 Port out_data_wr  output  1  out_data valid strobe.
REQ-016 Port out_valid / out_valid_wr  output  1 each  both high on the final word of each packet.
REQ-017 Port busy  output  1  high in any state other than IDLE.
REQ-018 Port done  output  1  one-cycle pulse when a run ends.
REQ-019 Port sent_cnt  output  32  packets completed in the current run; saturates at 32'hFFFFFFFF.

Function
REQ-020 States SHALL be IDLE, READ, GAP and DRAIN.
REQ-021 On start in IDLE, the block SHALL latch cfg_last_addr, cfg_pkt_cnt and cfg_gap, clear sent_cnt, and enter READ (or GAP when in_alf=1).
- Variation: with in_alf=1 the GAP counter loads 0 and the state holds GAP until in_alf=0.
REQ-022 start SHALL be ignored when the state is not IDLE.
REQ-023 READ SHALL assert ram_rd_en every cycle, with ram_rd_addr running 0..last_addr.
- Exit to GAP after issuing last_addr.
REQ-024 Each read SHALL appear on out_data/out_data_wr exactly 2 cycles after its ram_rd_en.
- One cycle is RAM latency; one cycle is the output register.
REQ-025 Start-to-first-word latency SHALL be 3 cycles.
- Start sampled in cycle 0; first out_data_wr in cycle 3.
REQ-026 GAP SHALL count latched cfg_gap cycles, then return to READ at address 0, so the output shows exactly cfg_gap idle cycles between packets.
- cfg_gap=0 gives back-to-back packets.
REQ-027 in_alf SHALL be sampled only on GAP exit; a packet already started always completes.
REQ-028 sent_cnt SHALL increment in the cycle after each out_valid_wr.
REQ-029 When sent_cnt reaches cfg_pkt_cnt (cfg_pkt_cnt≠0), the state SHALL go to DRAIN instead of READ.
REQ-030 When stop=1 at the end of a packet's read issue, or during GAP, the state SHALL go to DRAIN.
REQ-031 DRAIN SHALL wait until the pipeline is empty (2 cycles), then pulse done and enter IDLE.
REQ-032 last_addr=0 SHALL produce single-word packets, each with out_valid_wr set.
REQ-033 If stop and the count-reached condition coincide, the result SHALL be a single DRAIN and a single done pulse.
REQ-034 ram_rd_addr SHALL never exceed last_addr and SHALL never wrap past 127.

Reset
REQ-035 On rst, outputs SHALL immediately become:
- ram_rd_en=0, ram_rd_addr=0
- out_data=0, out_data_wr=0, out_valid=0, out_valid_wr=0
- busy=0, done=0, sent_cnt=0
- state=IDLE
REQ-036 Reset mid-packet SHALL drop the partial packet; no words are emitted after release until a new start.

Structure
REQ-037 A shared package SHALL hold:
- the state encoding;
- the word-tag constants: HEAD=2'b01, BODY=2'b11, TAIL=2'b10;
- the RAM depth (128) and width (144).
REQ-038 The gap/inter-packet counter SHALL be a sub-module pgm_gap_cnt (load, decrement, zero flag).

Verification
REQ-039 last_addr=3, pkt_cnt=2, gap=4, start -> words 0..3 in cycles 3-6, 4 idle cycles, words 0..3 in cycles 11-14, done in cycle 17, sent_cnt=2.
REQ-040 gap=0, pkt_cnt=3, last_addr=1 -> 6 consecutive out_data_wr cycles, with out_valid_wr on cycles 2, 4 and 6.
REQ-041 pkt_cnt=0 with stop raised mid-packet in run 5 -> the 5th packet completes, done pulses, sent_cnt=5.
REQ-042 in_alf=1 held for 10 cycles during GAP -> no new packet header until in_alf=0, and no mid-packet stall.
REQ-043 rst asserted on word 2 of a 4-word packet -> all outputs 0 immediately; a second start is ignored while busy; a start after release replays from address 0.
REQ-044 sent_cnt preloaded near saturation (force 32'hFFFFFFFE), pkt_cnt=0 -> sent_cnt holds at 32'hFFFFFFFF.
